// File: rtl/neuron_mac_seq_pkg.sv
// neuron_mac_seq_pkg: shared FSM states, accumulator sizing and saturation limits
package neuron_mac_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT} state_e;
  function automatic int acc_w(int w);
    return 2 * w + 4;
  endfunction
  function automatic int sat_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_min(int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/neuron_activation.sv
// neuron_activation: combinational floor-shift, optional ReLU and saturation to Width bits
module neuron_activation
  import neuron_mac_seq_pkg::*;
#(
  parameter int Width = 10,
  parameter int Frac  = 5,
  parameter int Relu  = 1,
  parameter int AccW  = 24
) (
  input  logic signed [AccW-1:0]  acc_i,
  output logic signed [Width-1:0] y_o
);
  localparam logic signed [AccW-1:0] MaxV = AccW'(sat_max(Width));
  localparam logic signed [AccW-1:0] MinV = AccW'(sat_min(Width));
  logic signed [AccW-1:0] r, rr;
  assign r   = acc_i >>> Frac;
  assign rr  = (Relu != 0 && r[AccW-1]) ? '0 : r;
  assign y_o = (rr > MaxV) ? MaxV[Width-1:0] : (rr < MinV) ? MinV[Width-1:0] : rr[Width-1:0];
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: snapshot 10 taps/weights, one MAC per cycle, then activate and pulse Valid
module neuron_mac_seq
  import neuron_mac_seq_pkg::*;
#(
  parameter int Width = 10,
  parameter int Frac  = 5,
  parameter int Relu  = 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    Start,
  input  logic signed [Width-1:0] X0, X1, X2, X3, X4, X5, X6, X7, X8, X9,
  input  logic signed [Width-1:0] W0, W1, W2, W3, W4, W5, W6, W7, W8, W9,
  input  logic signed [Width-1:0] Bias,
  output logic signed [Width-1:0] Y,
  output logic                    Valid,
  output logic                    Busy
);
  localparam int AccW = acc_w(Width);
  state_e                  state_q, state_d;
  logic signed [Width-1:0] x_in [10];
  logic signed [Width-1:0] w_in [10];
  logic signed [Width-1:0] xs_q [10];
  logic signed [Width-1:0] xs_d [10];
  logic signed [Width-1:0] ws_q [10];
  logic signed [Width-1:0] ws_d [10];
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [3:0]              idx_q, idx_d;
  logic signed [Width-1:0] y_q, y_d, act;
  logic                    valid_q, valid_d;
  logic signed [2*Width-1:0] prod;
  assign x_in = '{X0, X1, X2, X3, X4, X5, X6, X7, X8, X9};
  assign w_in = '{W0, W1, W2, W3, W4, W5, W6, W7, W8, W9};
  assign prod = xs_q[idx_q] * ws_q[idx_q];
  neuron_activation #(
    .Width(Width),
    .Frac (Frac),
    .Relu (Relu),
    .AccW (AccW)
  ) u_act (
    .acc_i(acc_q),
    .y_o  (act)
  );
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      xs_q    <= '{default: '0};
      ws_q    <= '{default: '0};
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ws_q    <= ws_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end
  // Bias is pre-scaled by Frac so it lines up with the Q(2*Frac) products
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ws_d    = ws_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    y_d     = y_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (Start) begin
        xs_d    = x_in;
        ws_d    = w_in;
        acc_d   = AccW'(Bias) <<< Frac;
        idx_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d   = acc_q + AccW'(prod);
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q == 4'd9) ? S_ACT : S_MAC;
      end
      S_ACT: begin
        y_d     = act;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign Y     = y_q;
  assign Valid = valid_q;
  assign Busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: scoreboard bench driving a ReLU and a linear instance with shared inputs
module tb_neuron_mac_seq;
  typedef struct { longint y; int c; } exp_t;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [9:0] x [10];
  logic signed [9:0] w [10];
  logic signed [9:0] bias;
  logic signed [9:0] y1, y0;
  logic v1, v0, b1, b0;
  int xa [10];
  int wa [10];
  int ba;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q1 [$];
  exp_t q0 [$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  neuron_mac_seq #(.Width(10), .Frac(5), .Relu(1)) u_relu (
    .CLK(CLK), .reset(reset), .Start(start),
    .X0(x[0]), .X1(x[1]), .X2(x[2]), .X3(x[3]), .X4(x[4]),
    .X5(x[5]), .X6(x[6]), .X7(x[7]), .X8(x[8]), .X9(x[9]),
    .W0(w[0]), .W1(w[1]), .W2(w[2]), .W3(w[3]), .W4(w[4]),
    .W5(w[5]), .W6(w[6]), .W7(w[7]), .W8(w[8]), .W9(w[9]),
    .Bias(bias), .Y(y1), .Valid(v1), .Busy(b1)
  );
  neuron_mac_seq #(.Width(10), .Frac(5), .Relu(0)) u_lin (
    .CLK(CLK), .reset(reset), .Start(start),
    .X0(x[0]), .X1(x[1]), .X2(x[2]), .X3(x[3]), .X4(x[4]),
    .X5(x[5]), .X6(x[6]), .X7(x[7]), .X8(x[8]), .X9(x[9]),
    .W0(w[0]), .W1(w[1]), .W2(w[2]), .W3(w[3]), .W4(w[4]),
    .W5(w[5]), .W6(w[6]), .W7(w[7]), .W8(w[8]), .W9(w[9]),
    .Bias(bias), .Y(y0), .Valid(v0), .Busy(b0)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint model(input bit relu);
    longint acc, r;
    acc = longint'(ba) * 32;
    for (int i = 0; i < 10; i++) acc += longint'(xa[i]) * longint'(wa[i]);
    r = acc >>> 5;
    if (relu && r < 0) r = 0;
    return (r > 511) ? 511 : (r < -512) ? -512 : r;
  endfunction

  function automatic void set_all(input int xv, input int wv, input int bv);
    for (int i = 0; i < 10; i++) begin
      xa[i] = xv;
      wa[i] = wv;
    end
    ba = bv;
  endfunction

  task automatic apply();
    for (int i = 0; i < 10; i++) begin
      x[i] = 10'(xa[i]);
      w[i] = 10'(wa[i]);
    end
    bias = 10'(ba);
  endtask

  // called at a negedge; the Start is sampled on the next edge k, result due at edge k+11
  task automatic go(input bit accept);
    apply();
    start = 1'b1;
    if (accept) begin
      q1.push_back('{model(1), cyc + 12});
      q0.push_back('{model(0), cyc + 12});
    end
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q1.size() + q0.size()) != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_pending", q1.size() + q0.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (v1) begin
      if (q1.size() == 0) chk("spurious_valid_relu", 1, 0);
      else begin
        e = q1.pop_front();
        chk("y_relu", y1, e.y);
        chk("lat_relu", cyc, e.c);
      end
    end
    if (v0) begin
      if (q0.size() == 0) chk("spurious_valid_lin", 1, 0);
      else begin
        e = q0.pop_front();
        chk("y_lin", y0, e.y);
        chk("lat_lin", cyc, e.c);
      end
    end
  end

  initial begin
    int nb, n;
    set_all(0, 0, 0);
    apply();
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    chk("rst_y", y1, 0);
    chk("rst_valid", v1 | v0, 0);
    chk("rst_busy", b1 | b0, 0);
    // unity sum, busy window
    set_all(32, 32, 0);
    go(1);
    nb = 0;
    for (int i = 0; i < 14; i++) begin
      nb += int'(b1);
      @(negedge CLK);
    end
    chk("busy_cycles", nb, 11);
    wait_idle();
    // sign and activation
    set_all(0, 0, 0); xa[0] = 32; wa[0] = -64;
    go(1); wait_idle();
    // saturation both ways
    set_all(511, 511, 0);
    go(1); wait_idle();
    set_all(511, -512, 0);
    go(1); wait_idle();
    // bias and floor truncation
    set_all(0, 0, 16);
    go(1); wait_idle();
    set_all(0, 0, 0); xa[0] = 1; wa[0] = -1;
    go(1); wait_idle();
    // random mixes
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 10; i++) begin
        xa[i] = $urandom_range(1023) - 512;
        wa[i] = $urandom_range(127) - 64;
      end
      ba = $urandom_range(1023) - 512;
      go(1); wait_idle();
    end
    // snapshot isolation plus ignored Starts mid-evaluation
    set_all(20, -7, 3);
    go(1);
    repeat (2) @(negedge CLK);
    set_all(100, 100, 100);
    go(0);
    repeat (3) @(negedge CLK);
    set_all(-200, 50, -9);
    go(0);
    wait_idle();
    repeat (12) @(negedge CLK);
    // Start in the Valid cycle
    set_all(32, 32, 0);
    go(1);
    n = 0;
    while (!v1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("valid_seen", v1, 1);
    set_all(-16, 32, 5);
    go(1);
    wait_idle();
    // reset mid-MAC aborts with no Valid
    set_all(7, 9, 1);
    go(1);
    repeat (5) @(negedge CLK);
    void'(q1.pop_back());
    void'(q0.pop_back());
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("abort_busy", b1 | b0, 0);
    chk("abort_y_relu", y1, 0);
    chk("abort_y_lin", y0, 0);
    chk("abort_valid", v1 | v0, 0);
    repeat (14) @(negedge CLK);
    set_all(32, 32, 0);
    go(1); wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
